// File: rtl/alpha_ctrl_pkg.sv
// alpha_ctrl_pkg
// Shared definitions for the alpha fade controller: the sequencer state
// encoding and the two level endpoints a fade can settle on.
package alpha_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RAMP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] ALPHA_MAX = 8'hFF;
    localparam logic [7:0] ALPHA_MIN = 8'h00;

endpackage

// File: rtl/pix_xy_cnt.sv
// pix_xy_cnt
// Tracks the current pixel position from the DE / vertical sync stream and
// produces a one-cycle frame-start pulse.
//
// Ports:
//   sys_clk     pixel clock
//   rst         asynchronous active-high reset
//   i_de        data enable of the incoming video stream
//   i_v_sync    vertical sync, active-high
//   o_x         column of the pixel currently on i_de
//   o_y         line of the pixel currently on i_de
//   o_vs_rise   registered pulse, high for one cycle after i_v_sync rises
module pix_xy_cnt
    import alpha_ctrl_pkg::*;
#(
    parameter int COORD_W = 12
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               i_de,
    input  logic               i_v_sync,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_vs_rise
);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_dePrev;
    logic               r_vsPrev;
    logic               r_vsRise;
    logic               w_deFall;
    logic               w_vsEdge;

    assign w_deFall = r_dePrev & ~i_de;
    assign w_vsEdge = i_v_sync & ~r_vsPrev;

    // Edge history for DE and vsync. The vsync edge is registered before it
    // leaves this block so the sequencer sees it one cycle after the edge.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_dePrev <= 1'b0;
            r_vsPrev <= 1'b0;
            r_vsRise <= 1'b0;
        end else begin
            r_dePrev <= i_de;
            r_vsPrev <= i_v_sync;
            r_vsRise <= w_vsEdge;
        end
    end

    // Column counter: the value seen during a DE cycle is the column of that
    // pixel, so the first active pixel of a line is column 0. The end of the
    // line (DE falling) rewinds it for the next line.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
        end else if (i_de) begin
            r_x <= r_x + 1'b1;
        end else if (w_deFall) begin
            r_x <= '0;
        end
    end

    // Line counter: advances at the end of each active line and rewinds at
    // frame start. A frame start wins over a coincident line end.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_y <= '0;
        end else if (w_vsEdge) begin
            r_y <= '0;
        end else if (w_deFall) begin
            r_y <= r_y + 1'b1;
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_vs_rise = r_vsRise;

endmodule

// File: rtl/alpha_fade_ctrl.sv
// alpha_fade_ctrl
// Per-frame alpha sequencer for the video alpha blender. A global blend level
// is ramped toward 255 (fade in) or 0 (fade out) in programmable steps, one
// step every N frames, and is only ever changed at frame start so a frame is
// never torn. Each pixel receives that level inside a rectangular window and
// 0 elsewhere.
//
// Ports:
//   sys_clk, rst                pixel clock, asynchronous active-high reset
//   i_v_sync, i_h_sync, i_de    video timing stream (h_sync is not needed)
//   cfg_start / cfg_abort       one-cycle pulses: begin fade / stop and hold
//   cfg_dir                     1 = toward 255, 0 = toward 0
//   cfg_step, cfg_frames        level increment, frames per step (0 means 1)
//   cfg_win_x0/x1/y0/y1         inclusive window bounds, used live
//   o_alpha_8b                  per-pixel alpha, one cycle behind i_de
//   o_level                     current global level
//   o_busy                      a fade is armed or ramping
//   o_done                      one-cycle pulse when a fade reaches its end
module alpha_fade_ctrl
    import alpha_ctrl_pkg::*;
#(
    parameter int COORD_W = 12
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               i_v_sync,
    input  logic               i_h_sync,
    input  logic               i_de,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic               cfg_dir,
    input  logic [7:0]         cfg_step,
    input  logic [7:0]         cfg_frames,
    input  logic [COORD_W-1:0] cfg_win_x0,
    input  logic [COORD_W-1:0] cfg_win_x1,
    input  logic [COORD_W-1:0] cfg_win_y0,
    input  logic [COORD_W-1:0] cfg_win_y1,
    output logic [7:0]         o_alpha_8b,
    output logic [7:0]         o_level,
    output logic               o_busy,
    output logic               o_done
);

    state_t             r_state;
    logic [7:0]         r_level;
    logic               r_dir;
    logic [7:0]         r_step;
    logic [7:0]         r_frames;
    logic [7:0]         r_frameCnt;
    logic               r_busy;
    logic               r_done;
    logic [7:0]         r_alpha;

    logic [COORD_W-1:0] w_x;
    logic [COORD_W-1:0] w_y;
    logic               w_vsRise;
    logic [8:0]         w_sum;
    logic [8:0]         w_diff;
    logic [7:0]         w_nextLevel;
    logic [7:0]         w_endpoint;
    logic               w_winValid;
    logic               w_inWin;
    logic               w_unused_hsync;

    assign w_unused_hsync = i_h_sync;

    pix_xy_cnt #(
        .COORD_W (COORD_W)
    ) u_pix_xy_cnt (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .i_de      (i_de),
        .i_v_sync  (i_v_sync),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_vs_rise (w_vsRise)
    );

    // Next level is computed one bit wider so the carry/borrow tells us when
    // to clamp to the endpoint instead of wrapping.
    assign w_sum       = {1'b0, r_level} + {1'b0, r_step};
    assign w_diff      = {1'b0, r_level} - {1'b0, r_step};
    assign w_nextLevel = r_dir ? (w_sum[8]  ? ALPHA_MAX : w_sum[7:0])
                               : (w_diff[8] ? ALPHA_MIN : w_diff[7:0]);
    assign w_endpoint  = r_dir ? ALPHA_MAX : ALPHA_MIN;

    // Sequencer. Abort overrides everything, including a same-cycle start,
    // and leaves the level where it is. Config is latched only when leaving
    // IDLE, so a start during a fade cannot alter the fade in flight. The
    // step and frame counts are normalised at latch time so 0 behaves as 1.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_level    <= ALPHA_MIN;
            r_dir      <= 1'b0;
            r_step     <= 8'd1;
            r_frames   <= 8'd1;
            r_frameCnt <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (cfg_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (cfg_start) begin
                        r_dir    <= cfg_dir;
                        r_step   <= (cfg_step == 8'd0) ? 8'd1 : cfg_step;
                        r_frames <= (cfg_frames == 8'd0) ? 8'd1 : cfg_frames;
                        r_busy   <= 1'b1;
                        r_state  <= ARM;
                    end
                end
                ARM: begin
                    if (w_vsRise) begin
                        r_frameCnt <= 8'd0;
                        r_state    <= RAMP;
                    end
                end
                RAMP: begin
                    if (w_vsRise) begin
                        if (r_frameCnt == (r_frames - 8'd1)) begin
                            r_frameCnt <= 8'd0;
                            r_level    <= w_nextLevel;
                            if (w_nextLevel == w_endpoint) begin
                                r_state <= DONE;
                            end
                        end else begin
                            r_frameCnt <= r_frameCnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Window test against the live bounds. An inverted range on either axis
    // means an empty window.
    assign w_winValid = (cfg_win_x0 <= cfg_win_x1) && (cfg_win_y0 <= cfg_win_y1);
    assign w_inWin    = (w_x >= cfg_win_x0) && (w_x <= cfg_win_x1) &&
                        (w_y >= cfg_win_y0) && (w_y <= cfg_win_y1);

    // Per-pixel alpha, registered; the blender delays its pixel path by one
    // cycle to line up with this.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_alpha <= 8'd0;
        end else if (i_de && w_winValid && w_inWin) begin
            r_alpha <= r_level;
        end else begin
            r_alpha <= 8'd0;
        end
    end

    assign o_alpha_8b = r_alpha;
    assign o_level    = r_level;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: doc/alpha_fade_ctrl.md
# alpha_fade_ctrl

Per-frame alpha sequencer that drives the alpha input of the video alpha blender. It ramps a global blend level between 0 and 255 in programmable steps at frame boundaries, giving tear-free fade-in and fade-out. Each pixel gets that level inside a rectangular overlay window and 0 (background only) outside it. The block sits beside the blender on the same pixel clock and consumes the same sync/DE stream.

## Interface
- COORD_W, 12, width of the x/y pixel counters and window bounds
- sys_clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-high
- i_v_sync  in  1  vertical sync, active-high
- i_h_sync  in  1  horizontal sync, active-high (not used for counting)
- i_de  in  1  data enable
- cfg_start  in  1  one-cycle pulse: latch config, begin fade
- cfg_abort  in  1  one-cycle pulse: stop fade, hold current level
- cfg_dir  in  1  1 = fade in (toward 255), 0 = fade out (toward 0)
- cfg_step  in  8  level increment per step; 0 treated as 1
- cfg_frames  in  8  frames per step; 0 treated as 1
- cfg_win_x0, cfg_win_x1, cfg_win_y0, cfg_win_y1  in  COORD_W  inclusive window bounds
- o_alpha_8b  out  8  per-pixel alpha to the blender
- o_level  out  8  current global level
- o_busy  out  1  high in ARM and RAMP
- o_done  out  1  one-cycle pulse when the ramp reaches its endpoint

## Operation
- Reset values:
  - o_alpha_8b=0, o_level=0, o_busy=0, o_done=0
  - state IDLE; x, y and frame counters 0
- Pixel position:
  - x increments on each i_de cycle and clears on i_de falling edge.
  - y increments on i_de falling edge and clears on i_v_sync rising edge.
  - Both counters wrap at 2^COORD_W.
- Pixel alpha: registered; equals o_level when i_de=1 and x0<=x<=x1 and y0<=y<=y1, else 0.
- Empty window: if x0>x1 or y0>y1, alpha is always 0.
- Window bounds are sampled live, not latched.
- vs_rise: i_v_sync registered once; vs_rise = i_v_sync & ~prev.
- FSM:
  - IDLE: on cfg_start, latch dir/step/frames and go to ARM.
  - ARM: on vs_rise, clear frame_cnt and go to RAMP.
  - RAMP: on each vs_rise, if frame_cnt==frames-1 then clear frame_cnt and apply a step; else increment frame_cnt.
  - Step: level = dir ? min(level+step, 255) : max(level-step, 0), computed 9-bit then saturated.
  - When the stepped level equals the endpoint (255 for dir=1, 0 for dir=0), go to DONE.
  - DONE: assert o_done for one cycle, go to IDLE.
- Already at endpoint: a start when level already equals the endpoint still passes through ARM and RAMP. The first step saturates, giving DONE with level unchanged.
- cfg_abort: from any state, go to IDLE. Level holds and o_done is not pulsed.
- Simultaneous cfg_start and cfg_abort: abort wins, no start.
- cfg_start while busy: ignored; the latched config does not change.
- o_level changes only on vs_rise, so the window alpha is constant across a frame.

## Timing
- o_alpha_8b lags i_de/position by 1 cycle. The integrator delays the blender's pixel and sync inputs by 1 cycle to align.
- vs_rise is detected 1 cycle after i_v_sync rises. o_level updates the cycle after that (2 cycles after the edge).
- o_done is asserted 1 cycle after the final level update. o_busy falls in that same cycle.
- Abort takes effect the cycle after the pulse, and o_busy drops then.
- Reset asserted mid-ramp forces the reset values immediately. Ramp progress is not resumed.

## Structure
- Package alpha_ctrl_pkg holds:
  - state enum {IDLE, ARM, RAMP, DONE}
  - ALPHA_MAX = 8'hFF, ALPHA_MIN = 8'h00
- Sub-module pix_xy_cnt: x/y counters and vs_rise from i_de/i_v_sync, parameterised by COORD_W.
- Top level holds the FSM, level arithmetic and window compare.

## Test plan
- Fade in, 4 vsyncs: level 0, dir=1, step=64, frames=1. o_level goes 64, 128, 192, 255, and o_done pulses after the 4th vsync.
- Fade out, 4 vsyncs: level 255, dir=0, step=128, frames=2. o_level goes 127 after 2 vsyncs, then 0 after 4 vsyncs, then o_done.
- Window: level 200, window x 10..19, y 2..3. o_alpha_8b is 200 only for those 20 pixels (one cycle after DE), 0 elsewhere and during blanking.
- Abort mid-ramp: step=16, abort after 3 steps. o_level holds 48, o_busy drops, no o_done; a new start resumes from 48.
- Start and abort in the same cycle: FSM stays in IDLE and o_busy stays 0. A start while in RAMP with different step does not change the step.
- Async reset mid-RAMP: all outputs go to 0 without a clock. step=0, frames=0 behaves as step 1 per frame (level 0 to 1 after 1 vsync).
